// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation runs IDLE -> EXEC -> RESP and returns on the owner's channel.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int FUN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FUN_W-1:0] req0_fun,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_result,
    input  logic             rsp0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FUN_W-1:0] req1_fun,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FUN_W-1:0] alu_fun,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t             state;
    logic               owner;
    logic               last_gnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [FUN_W-1:0]   fun_q;
    logic [WIDTH-1:0]   res_q;
    logic               gnt1;
    logic               idle;
    logic               rsp_done;

    // Requester 1 wins when alone, or on a tie when requester 0 went last.
    assign gnt1 = req1_valid & (~req0_valid | ~last_gnt);
    assign idle = (state == IDLE);

    assign req0_ready = idle & req0_valid & ~gnt1;
    assign req1_ready = idle & gnt1;
    assign rsp_done   = owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            res_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        owner    <= gnt1;
                        last_gnt <= gnt1;
                        a_q      <= gnt1 ? req1_a : req0_a;
                        b_q      <= gnt1 ? req1_b : req0_b;
                        fun_q    <= gnt1 ? req1_fun : req0_fun;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res_q <= alu_result;
                    state <= RESP;
                end
                RESP: begin
                    // Clearing the operand regs keeps the ALU inputs at zero in IDLE.
                    if (rsp_done) begin
                        a_q   <= '0;
                        b_q   <= '0;
                        fun_q <= '0;
                        res_q <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_fun = fun_q;
    assign busy    = ~idle;

    assign rsp0_valid  = (state == RESP) & ~owner;
    assign rsp1_valid  = (state == RESP) & owner;
    assign rsp0_result = rsp0_valid ? res_q : '0;
    assign rsp1_result = rsp1_valid ? res_q : '0;

endmodule
